hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising-edge; reset  in  1  synchronous, active-high.
REQ-002 SHALL have ports: id_rs1, id_rs2  in  5  source register indices of the decode-stage instruction; id_rs1_used, id_rs2_used  in  1  the source is actually read.
REQ-003 SHALL have ports: id_rd  in  5  decode-stage destination; id_regwen  in  1  decode-stage writes rd; id_is_load  in  1  decode-stage WBSel selects memory data; id_valid  in  1  decode stage holds a real instruction.
REQ-004 SHALL have port: ex_branch_taken  in  1  EX-stage redirect (taken branch or jump) this cycle.
REQ-005 SHALL have ports: stall_if_id  out  1  hold PC and IF/ID; flush_if_id  out  1  squash IF/ID; flush_id_ex  out  1  load a bubble into ID/EX.
REQ-006 SHALL have ports: hazardSelA, hazardSelB  out  2  EX operand forwarding selects: 00 = register file, 01 = EX/MA ALU_Result, 10 = MA/WB WB_Result, 11 = never driven.

Function
REQ-007 SHALL keep three internal shadow stages that mirror the pipeline registers: S_EX {rd, regwen, load}, S_MA {rd, regwen}, S_WB {rd, regwen}.
REQ-008 SHALL advance the shadow stages on each clock edge: S_WB <= S_MA; S_MA <= S_EX; S_EX <= decode fields, or a bubble (regwen = 0) when flush_id_ex = 1 or id_valid = 0.
REQ-009 SHALL treat rd = 0 as non-writing: x0 never matches, never forwards and never stalls.
REQ-010 SHALL assert stall_if_id and flush_id_ex combinationally for a load-use hazard: S_EX.load = 1, S_EX.regwen = 1, and (id_rs1_used and id_rs1 = S_EX.rd) or (id_rs2_used and id_rs2 = S_EX.rd).
REQ-011 SHALL limit each load-use stall to exactly one cycle, because the load leaves S_EX on the next edge.
REQ-012 SHALL, when ex_branch_taken = 1, assert flush_if_id and flush_id_ex, and force stall_if_id = 0 in the same cycle; a branch overrides any concurrent load-use stall.
REQ-013 SHALL register hazardSelA and hazardSelB on each edge for the instruction entering EX, computed per source (rs1 -> A, rs2 -> B):
- 01 if the source is used, S_EX.regwen = 1 and the source equals S_EX.rd;
- else 10 if the source is used, S_MA.regwen = 1 and the source equals S_MA.rd;
- else 00.
REQ-014 SHALL give the nearest producer priority (01 over 10) when both shadow stages match.
REQ-015 SHALL register hazardSel = 00 for any bubble entering EX (flush_id_ex = 1 or id_valid = 0).
REQ-016 SHALL rely on the register file's write-before-read for producers three or more instructions ahead; no select value is generated for S_WB.
REQ-017 SHALL have zero-cycle latency for stall and flush outputs and one-cycle latency for the hazardSel outputs.

Reset
REQ-018 SHALL, while reset = 1 at a rising edge, clear all shadow stages (rd = 0, regwen = 0, load = 0) and set hazardSelA = hazardSelB = 00.
REQ-019 SHALL drive stall_if_id = flush_if_id = 0 and flush_id_ex = 1 during reset, independent of other inputs.
REQ-020 SHALL treat reset asserted mid-stall or mid-flush as overriding: the cycle after reset deasserts has no pending stall or forwarding.

Configuration
REQ-021 SHALL, when macro HAZARD_CTRL_PERF_CNT_EN is defined, add outputs stall_count (32 bits) and flush_count (32 bits).
- stall_count increments on each cycle with stall_if_id = 1; flush_count increments on each cycle with flush_if_id = 1.
- Both counters saturate at 0xFFFFFFFF and clear on reset.
REQ-022 SHALL, without HAZARD_CTRL_PERF_CNT_EN, omit those ports and counters entirely; all other behaviour is identical.

Verification
REQ-023 SHALL cover back-to-back ALU dependency: add x5 <- ..., then add x6 <- x5, x5 -> hazardSelA = 01 and hazardSelB = 01 in the consumer's EX cycle, no stall.
REQ-024 SHALL cover distance-2 dependency: producer x7, one independent instruction, consumer reads x7 on rs2 -> hazardSelB = 10, hazardSelA = 00.
REQ-025 SHALL cover load-use: lw x8, then add x9 <- x8 -> stall_if_id = 1 and flush_id_ex = 1 for exactly one cycle, then hazardSelA = 10 in the consumer's EX cycle.
REQ-026 SHALL cover x0: producer rd = 0, consumer rs1 = 0 -> hazardSelA = 00, and a load to x0 does not stall.
REQ-027 SHALL cover branch over stall: load-use condition and ex_branch_taken = 1 in the same cycle -> stall_if_id = 0, flush_if_id = 1, flush_id_ex = 1; with HAZARD_CTRL_PERF_CNT_EN, flush_count +1 and stall_count unchanged.
REQ-028 SHALL cover reset during stall: assert reset in a stall cycle -> next cycle all shadow stages are empty, hazardSel = 00, stall_if_id = 0 and counters = 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// ----------------------------------------------------------------------------
// hazard_ctrl
//   Data/control hazard unit for a 5-stage in-order pipeline
//   (IF, ID, EX, MA, WB). The unit keeps its own shadow copy of the
//   destination information held in ID/EX, EX/MA and MA/WB. From that copy it
//   detects load-use stalls and branch flushes in the current cycle, and it
//   registers the EX operand forwarding selects for the instruction that
//   enters EX on the next edge.
//
// Ports
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_rs1/id_rs2         decode-stage source indices
//   id_rs1_used/_rs2_used the source is actually read
//   id_rd, id_regwen      decode-stage destination and its write enable
//   id_is_load            decode-stage result comes from memory
//   id_valid              decode stage holds a real instruction
//   ex_branch_taken       EX redirect this cycle
//   stall_if_id           hold PC and IF/ID (combinational)
//   flush_if_id           squash IF/ID (combinational)
//   flush_id_ex           load a bubble into ID/EX (combinational)
//   hazardSelA/B          registered EX operand selects:
//                         00 regfile, 01 EX/MA ALU_Result, 10 MA/WB WB_Result
//
// Optional feature (macro HAZARD_CTRL_PERF_CNT_EN)
//   stall_count, flush_count: saturating 32-bit event counters.
// ----------------------------------------------------------------------------
module hazard_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_rs1_used,
    input  logic       id_rs2_used,
    input  logic [4:0] id_rd,
    input  logic       id_regwen,
    input  logic       id_is_load,
    input  logic       id_valid,
    input  logic       ex_branch_taken,
    output logic       stall_if_id,
    output logic       flush_if_id,
    output logic       flush_id_ex,
    output logic [1:0] hazardSelA,
    output logic [1:0] hazardSelB
`ifdef HAZARD_CTRL_PERF_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] flush_count
`endif
);

    localparam logic [1:0] SEL_RF = 2'b00;
    localparam logic [1:0] SEL_EX = 2'b01;
    localparam logic [1:0] SEL_MA = 2'b10;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwen;
        logic       load;
    } ex_shadow_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       regwen;
    } shadow_t;

    ex_shadow_t s_ex_q, s_ex_d;
    shadow_t    s_ma_q, s_wb_q;
    logic [1:0] sel_a_q, sel_a_d;
    logic [1:0] sel_b_q, sel_b_d;

    logic       load_use;
    logic       bubble;

    // A producer in EX/MA (distance 1) wins over MA/WB (distance 2).
    // x0 never forwards; regwen in the shadow is already cleared for rd=0.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       used,
                                           input ex_shadow_t ex,
                                           input shadow_t    ma);
        logic [1:0] sel;
        sel = SEL_RF;
        if (used && src != 5'd0) begin
            if (ex.regwen && ex.rd == src)
                sel = SEL_EX;
            else if (ma.regwen && ma.rd == src)
                sel = SEL_MA;
        end
        return sel;
    endfunction

    // Load in EX whose data is only available after MA: the dependent
    // instruction in ID must wait one cycle.
    always_comb begin
        load_use = 1'b0;
        if (s_ex_q.load && s_ex_q.regwen && s_ex_q.rd != 5'd0) begin
            if ((id_rs1_used && id_rs1 == s_ex_q.rd) ||
                (id_rs2_used && id_rs2 == s_ex_q.rd))
                load_use = 1'b1;
        end
    end

    // Branch redirect wins over a load-use stall: the stalled instruction
    // is on the wrong path anyway. Reset forces a bubble into ID/EX.
    assign stall_if_id = !reset && load_use && !ex_branch_taken;
    assign flush_if_id = !reset && ex_branch_taken;
    assign flush_id_ex = reset || load_use || ex_branch_taken;

    assign bubble = flush_id_ex || !id_valid;

    always_comb begin
        s_ex_d  = '0;
        sel_a_d = SEL_RF;
        sel_b_d = SEL_RF;
        if (!bubble) begin
            s_ex_d.rd     = id_rd;
            s_ex_d.regwen = id_regwen && (id_rd != 5'd0);
            s_ex_d.load   = id_is_load;
            sel_a_d       = fwd_sel(id_rs1, id_rs1_used, s_ex_q, s_ma_q);
            sel_b_d       = fwd_sel(id_rs2, id_rs2_used, s_ex_q, s_ma_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_ex_q  <= '0;
            s_ma_q  <= '0;
            s_wb_q  <= '0;
            sel_a_q <= SEL_RF;
            sel_b_q <= SEL_RF;
        end else begin
            // S_WB is tracked for completeness only; producers three or more
            // ahead are covered by the register file's write-before-read.
            s_wb_q  <= s_ma_q;
            s_ma_q  <= '{rd: s_ex_q.rd, regwen: s_ex_q.regwen};
            s_ex_q  <= s_ex_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
        end
    end

    assign hazardSelA = sel_a_q;
    assign hazardSelB = sel_b_q;

`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_if_id && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_if_id && flush_cnt_q != 32'hFFFF_FFFF)
                flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_rs1_used, id_rs2_used, id_regwen, id_is_load, id_valid;
    logic       ex_branch_taken;
    logic       stall_if_id, flush_if_id, flush_id_ex;
    logic [1:0] hazardSelA, hazardSelB;
`ifdef HAZARD_CTRL_PERF_CNT_EN
    logic [31:0] stall_count, flush_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rd(id_rd), .id_regwen(id_regwen), .id_is_load(id_is_load),
        .id_valid(id_valid), .ex_branch_taken(ex_branch_taken),
        .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
        .flush_id_ex(flush_id_ex),
        .hazardSelA(hazardSelA), .hazardSelB(hazardSelB)
`ifdef HAZARD_CTRL_PERF_CNT_EN
        , .stall_count(stall_count), .flush_count(flush_count)
`endif
    );

    // ---------------- reference model ----------------
    // hist[0] is the instruction now in EX, hist[1] the one in MA.
    typedef struct {
        int rd;
        bit wen;
        bit ld;
    } ent_t;

    ent_t     hist[$];
    bit [1:0] m_sel_a, m_sel_b;
    longint   m_stalls, m_flushes;

    function automatic ent_t bub();
        ent_t e;
        e.rd = 0; e.wen = 0; e.ld = 0;
        return e;
    endfunction

    function automatic bit m_loaduse();
        int p;
        p = hist[0].rd;
        if (!(hist[0].ld && hist[0].wen) || p == 0) return 0;
        return (id_rs1_used && int'(id_rs1) == p) || (id_rs2_used && int'(id_rs2) == p);
    endfunction

    // Distance to nearest in-flight producer of src: 1 -> 01, 2 -> 10.
    function automatic bit [1:0] m_src(input int src, input bit used);
        if (!used || src == 0) return 2'd0;
        for (int d = 0; d < 2; d++)
            if (hist[d].wen && hist[d].rd == src) return 2'(d + 1);
        return 2'd0;
    endfunction

    function automatic bit m_stall(); return !reset && m_loaduse() && !ex_branch_taken; endfunction
    function automatic bit m_fif();   return !reset && ex_branch_taken;                 endfunction
    function automatic bit m_fex();   return reset || m_loaduse() || ex_branch_taken;   endfunction

    task automatic model_step();
        ent_t e;
        bit   bubble;
        if (reset) begin
            hist = {bub(), bub()};
            m_sel_a = 0; m_sel_b = 0; m_stalls = 0; m_flushes = 0;
            return;
        end
        bubble = m_fex() || !id_valid;
        if (m_stall() && m_stalls < 64'hFFFF_FFFF) m_stalls++;
        if (m_fif() && m_flushes < 64'hFFFF_FFFF) m_flushes++;
        m_sel_a = bubble ? 2'd0 : m_src(int'(id_rs1), id_rs1_used);
        m_sel_b = bubble ? 2'd0 : m_src(int'(id_rs2), id_rs2_used);
        e = bub();
        if (!bubble) begin
            e.rd = int'(id_rd); e.wen = id_regwen && id_rd != 0; e.ld = id_is_load;
        end
        hist.push_front(e);
        void'(hist.pop_back());
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_rd = 0; id_regwen = 0; id_is_load = 0; id_valid = 0;
        ex_branch_taken = 0;
    endtask

    task automatic issue(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wen,
                         input logic ld, input logic br);
        id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_regwen = wen; id_is_load = ld; id_valid = 1;
        ex_branch_taken = br;
    endtask

    task automatic drain();
        idle(); tick(); tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1;
        issue(5'd3, 1, 5'd4, 1, 5'd3, 1, 1, 1);
        #1;
        checks++; if (stall_if_id !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_if_id); end
        checks++; if (flush_if_id !== 1'b0) begin errors++; $display("FAIL reset_flush_if_id got=%b exp=0", flush_if_id); end
        checks++; if (flush_id_ex !== 1'b1) begin errors++; $display("FAIL reset_flush_id_ex got=%b exp=1", flush_id_ex); end
        tick(); tick();
        checks++; if (hazardSelA !== 2'b00 || hazardSelB !== 2'b00) begin errors++; $display("FAIL reset_sel got=%b/%b exp=00/00", hazardSelA, hazardSelB); end
`ifdef HAZARD_CTRL_PERF_CNT_EN
        checks++; if (stall_count !== 0 || flush_count !== 0) begin errors++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", stall_count, flush_count); end
`endif
        reset = 0;
        drain();
    endtask

    task automatic test_back_to_back();
        drain();
        issue(5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0); #1; tick();
        issue(5'd5, 1, 5'd5, 1, 5'd6, 1, 0, 0); #1;
        checks++; if (stall_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL b2b_no_stall got=%b%b exp=00", stall_if_id, flush_id_ex); end
        tick();
        checks++; if (hazardSelA !== 2'b01) begin errors++; $display("FAIL b2b_selA got=%b exp=01", hazardSelA); end
        checks++; if (hazardSelB !== 2'b01) begin errors++; $display("FAIL b2b_selB got=%b exp=01", hazardSelB); end
    endtask

    task automatic test_distance2();
        drain();
        issue(5'd0, 0, 5'd0, 0, 5'd7, 1, 0, 0); #1; tick();
        issue(5'd1, 1, 5'd2, 1, 5'd10, 1, 0, 0); #1; tick();
        issue(5'd3, 1, 5'd7, 1, 5'd11, 1, 0, 0); #1; tick();
        checks++; if (hazardSelB !== 2'b10) begin errors++; $display("FAIL dist2_selB got=%b exp=10", hazardSelB); end
        checks++; if (hazardSelA !== 2'b00) begin errors++; $display("FAIL dist2_selA got=%b exp=00", hazardSelA); end
    endtask

    task automatic test_load_use();
        drain();
        issue(5'd2, 1, 5'd0, 0, 5'd8, 1, 1, 0); #1; tick();
        issue(5'd8, 1, 5'd3, 1, 5'd9, 1, 0, 0); #1;
        checks++; if (stall_if_id !== 1'b1 || flush_id_ex !== 1'b1 || flush_if_id !== 1'b0) begin errors++; $display("FAIL lu_stall got=%b%b%b exp=110", stall_if_id, flush_id_ex, flush_if_id); end
        tick();
        checks++; if (hazardSelA !== 2'b00 || hazardSelB !== 2'b00) begin errors++; $display("FAIL lu_bubble_sel got=%b/%b exp=00/00", hazardSelA, hazardSelB); end
        #1;
        checks++; if (stall_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL lu_one_cycle got=%b%b exp=00", stall_if_id, flush_id_ex); end
        tick();
        checks++; if (hazardSelA !== 2'b10) begin errors++; $display("FAIL lu_selA got=%b exp=10", hazardSelA); end
    endtask

    task automatic test_x0();
        drain();
        issue(5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0); #1; tick();
        issue(5'd0, 1, 5'd0, 1, 5'd4, 1, 0, 0); #1; tick();
        checks++; if (hazardSelA !== 2'b00 || hazardSelB !== 2'b00) begin errors++; $display("FAIL x0_sel got=%b/%b exp=00/00", hazardSelA, hazardSelB); end
        issue(5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0); #1; tick();
        issue(5'd0, 1, 5'd0, 1, 5'd4, 1, 0, 0); #1;
        checks++; if (stall_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin errors++; $display("FAIL x0_load_stall got=%b%b exp=00", stall_if_id, flush_id_ex); end
        tick();
    endtask

    task automatic test_branch_over_stall();
`ifdef HAZARD_CTRL_PERF_CNT_EN
        logic [31:0] sc, fc;
`endif
        drain();
        issue(5'd2, 1, 5'd0, 0, 5'd8, 1, 1, 0); #1; tick();
        issue(5'd8, 1, 5'd8, 1, 5'd9, 1, 0, 1); #1;
        checks++; if (stall_if_id !== 1'b0 || flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin errors++; $display("FAIL br_over_stall got=%b%b%b exp=011", stall_if_id, flush_if_id, flush_id_ex); end
`ifdef HAZARD_CTRL_PERF_CNT_EN
        sc = stall_count; fc = flush_count;
`endif
        tick();
        checks++; if (hazardSelA !== 2'b00 || hazardSelB !== 2'b00) begin errors++; $display("FAIL br_bubble_sel got=%b/%b exp=00/00", hazardSelA, hazardSelB); end
`ifdef HAZARD_CTRL_PERF_CNT_EN
        checks++; if (stall_count !== sc || flush_count !== fc + 32'd1) begin errors++; $display("FAIL br_counters got=%0d/%0d exp=%0d/%0d", stall_count, flush_count, sc, fc + 32'd1); end
`endif
        idle();
    endtask

    task automatic test_reset_during_stall();
        drain();
        issue(5'd1, 1, 5'd0, 0, 5'd12, 1, 1, 0); #1; tick();
        issue(5'd0, 0, 5'd12, 1, 5'd13, 1, 0, 0); #1;
        checks++; if (stall_if_id !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got=%b exp=1", stall_if_id); end
        reset = 1; #1;
        checks++; if (stall_if_id !== 1'b0 || flush_id_ex !== 1'b1) begin errors++; $display("FAIL rst_in_stall got=%b%b exp=01", stall_if_id, flush_id_ex); end
        tick();
        reset = 0; #1;
        checks++; if (stall_if_id !== 1'b0 || hazardSelA !== 2'b00 || hazardSelB !== 2'b00) begin errors++; $display("FAIL rst_after got=%b %b/%b exp=0 00/00", stall_if_id, hazardSelA, hazardSelB); end
`ifdef HAZARD_CTRL_PERF_CNT_EN
        checks++; if (stall_count !== 0 || flush_count !== 0) begin errors++; $display("FAIL rst_counters got=%0d/%0d exp=0/0", stall_count, flush_count); end
`endif
        tick();
        checks++; if (hazardSelB !== 2'b00) begin errors++; $display("FAIL rst_no_fwd got=%b exp=00", hazardSelB); end
    endtask

    task automatic test_random();
        bit es, ei, ee;
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(0, 59) == 0);
            issue(5'($urandom_range(0, 3)), 1'($urandom), 5'($urandom_range(0, 3)), 1'($urandom),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 7) == 0));
            id_valid = ($urandom_range(0, 7) != 0);
            #1;
            es = m_stall(); ei = m_fif(); ee = m_fex();
            checks++; if ({stall_if_id, flush_if_id, flush_id_ex} !== {es, ei, ee}) begin errors++; $display("FAIL rnd_comb n=%0d got=%b%b%b exp=%b%b%b", n, stall_if_id, flush_if_id, flush_id_ex, es, ei, ee); end
            tick();
            checks++; if (hazardSelA !== m_sel_a || hazardSelB !== m_sel_b) begin errors++; $display("FAIL rnd_sel n=%0d got=%b/%b exp=%b/%b", n, hazardSelA, hazardSelB, m_sel_a, m_sel_b); end
        end
        reset = 0;
`ifdef HAZARD_CTRL_PERF_CNT_EN
        checks++; if (stall_count !== 32'(m_stalls) || flush_count !== 32'(m_flushes)) begin errors++; $display("FAIL rnd_counters got=%0d/%0d exp=%0d/%0d", stall_count, flush_count, m_stalls, m_flushes); end
`endif
    endtask

    initial begin
        hist = {bub(), bub()};
        m_sel_a = 0; m_sel_b = 0; m_stalls = 0; m_flushes = 0;
        idle();
        test_reset();
        test_back_to_back();
        test_distance2();
        test_load_use();
        test_x0();
        test_branch_over_stall();
        test_reset_during_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
